muldiv_seq: RTL and testbench

Sequencer for the HI/LO multiply/divide resource in the EX stage of the 5-stage pipeline. It accepts one mult/div operation per start pulse from the ID/EX register and models the fixed multi-cycle latency of the unit. It owns the HI and LO registers, handles MTHI/MTLO writes, and produces the busy/stall signals the hazard unit needs to hold MFHI/MFLO and further mult/div instructions in ID.

---
 rtl/md_pkg.sv | 36 +++
 rtl/muldiv_seq.sv | 128 ++++++++++++
 tb/tb_muldiv_seq.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide resource.
// Used by the EX-stage sequencer (muldiv_seq) and the ID-stage decoder.
// Contents: op encodings, sequencer state encoding, default latencies and
// a helper that sizes the latency counter.
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_MUL_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF = 10;

    // Counter width: holds (max latency - 1), never narrower than 4 bits.
    function automatic int unsigned md_cnt_width(input int unsigned mul_cycles,
                                                 input int unsigned div_cycles);
        int unsigned max_cycles;
        int unsigned w;
        max_cycles = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        w = $clog2(max_cycles);
        return (w < 4) ? 4 : w;
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: EX-stage sequencer for the HI/LO multiply/divide resource.
// The result is computed combinationally when start is accepted and parked
// in pend_hi/pend_lo; the FSM then only models the fixed unit latency and
// commits the pending result to HI/LO when the count expires.
//
// Ports:
//   clk, reset      pipeline clock, synchronous active-high reset
//   start, op       mult/div issue pulse and operation (sampled with start)
//   mthi, mtlo      MTHI/MTLO writes of a into HI/LO (idle only)
//   a, b            rs/rt operands (forwarded)
//   md_use_id       ID holds a HI/LO-using instruction
//   busy            operation in flight (registered)
//   md_stall        md_use_id & (busy | start), to the hazard unit
//   hi, lo          HI and LO registers
module muldiv_seq
    import md_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MD_MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_id,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CntW = md_cnt_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

    md_state_e       state;
    logic [CntW-1:0] cnt;
    logic [31:0]     pend_hi;
    logic [31:0]     pend_lo;
    logic            pend_wr;

    // Arithmetic evaluated on the start cycle
    md_op_e             op_e;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic        [31:0] div_b;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic        [31:0] res_hi;
    logic        [31:0] res_lo;

    assign op_e     = md_op_e'(op);
    assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u   = {32'b0, a} * {32'b0, b};
    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    // Substituting 1 as divisor keeps the dividers well defined; for the
    // signed overflow case it yields exactly quotient=a, remainder=0.
    assign div_b    = (div_zero || (div_ovf && op_e == MD_DIV)) ? 32'd1 : b;
    assign quo_s    = $signed(a) / $signed(div_b);
    assign rem_s    = $signed(a) % $signed(div_b);
    assign quo_u    = a / div_b;
    assign rem_u    = a % div_b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        unique case (op_e)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV:   begin res_hi = rem_s; res_lo = quo_s; end
            MD_DIVU:  begin res_hi = rem_u; res_lo = quo_u; end
        endcase
    end

    assign md_stall = md_use_id & (busy | start);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        // Divide by zero still runs full length but leaves HI/LO alone
                        pend_wr <= !(md_is_div(op_e) && div_zero);
                        cnt     <= md_is_div(op_e) ? DivLoad : MulLoad;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        if (mthi) hi <= a;
                        if (mtlo) lo <= a;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    localparam int unsigned MUL_N = 5;
    localparam int unsigned DIV_N = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_id;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_seq #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .a         (a),
        .b         (b),
        .md_use_id (md_use_id),
        .busy      (busy),
        .md_stall  (md_stall),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;
    bit          abort = 0;
    bit          allow_illegal = 0;
    int          illegal_cnt = 0;
    int          run_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Reference model: architectural effect of one mult/div on HI/LO
    function automatic void model(input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y,
                                  inout logic [31:0] h, inout logic [31:0] l);
        longint          ps;
        longint unsigned pu;
        int              sq;
        int              sr;
        case (o)
            2'd0: begin
                ps = longint'($signed(x)) * longint'($signed(y));
                h = ps[63:32];
                l = ps[31:0];
            end
            2'd1: begin
                pu = {32'b0, x} * {32'b0, y};
                h = pu[63:32];
                l = pu[31:0];
            end
            2'd2: begin
                if (y != 0) begin
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        l = x;
                        h = 32'd0;
                    end else begin
                        sq = $signed(x) / $signed(y);
                        sr = $signed(x) % $signed(y);
                        l = sq;
                        h = sr;
                    end
                end
            end
            default: begin
                if (y != 0) begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endfunction

    // Monitor: a falling busy marks a commit; compare HI/LO and busy length
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            run_len++;
        end else if (run_len > 0) begin
            if (abort) begin
                abort = 0;
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got hi=%h lo=%h expected none", hi, lo);
            end else begin
                e = sb.pop_front();
                chk("commit_hi", hi, e.hi);
                chk("commit_lo", lo, e.lo);
                chk("busy_cycles", run_len, e.cycles);
            end
            run_len = 0;
        end
    end

    // Issue while busy is a hazard-unit bug unless deliberately injected
    always @(negedge clk) begin
        if (!reset && busy && (start || mthi || mtlo)) begin
            illegal_cnt++;
            assert (allow_illegal) else $error("issue while busy");
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=1 expected 0 within 40 cycles");
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic use_id);
        exp_t e;
        start     = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        md_use_id = use_id;
        #1;
        chk("stall_at_start", md_stall, use_id);
        model(o, x, y, ref_hi, ref_lo);
        e.hi = ref_hi;
        e.lo = ref_lo;
        e.cycles = o[1] ? DIV_N : MUL_N;
        sb.push_back(e);
        tick();
        start     = 1'b0;
        md_use_id = 1'b0;
        wait_idle();
    endtask

    task automatic mt(input logic wh, input logic wl, input logic [31:0] x);
        mthi = wh;
        mtlo = wl;
        a    = x;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        if (wh) ref_hi = x;
        if (wl) ref_lo = x;
        chk("mt_hi", hi, ref_hi);
        chk("mt_lo", lo, ref_lo);
        chk("mt_busy", busy, 1'b0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        start = 1'b0;
        op = 2'd0;
        mthi = 1'b0;
        mtlo = 1'b0;
        a = 32'd0;
        b = 32'd0;
        md_use_id = 1'b1;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall_idle", md_stall, 1'b0);
        start = 1'b1;
        #1;
        chk("rst_stall_start", md_stall, 1'b1);
        start = 1'b0;
        md_use_id = 1'b0;
        tick();
        reset = 1'b0;

        // Directed cases
        issue(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFFA);
        issue(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        issue(2'd3, 32'd7, 32'd0, 1'b0);
        chk("divu_zero_hi", hi, 32'hFFFF_FFFF);
        chk("divu_zero_lo", lo, 32'hFFFF_FFFD);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_hi", hi, 32'd0);
        chk("div_ovf_lo", lo, 32'h8000_0000);

        mt(1'b1, 1'b0, 32'h1234_5678);
        mt(1'b0, 1'b1, 32'h9ABC_DEF0);
        chk("mthi_val", hi, 32'h1234_5678);
        chk("mtlo_val", lo, 32'h9ABC_DEF0);
        mt(1'b1, 1'b1, 32'h0BAD_F00D);

        // MULT with MFLO in ID, plus an injected start while busy
        begin
            exp_t e;
            start = 1'b1;
            op = 2'd0;
            a = 32'd5;
            b = 32'd7;
            md_use_id = 1'b1;
            #1;
            chk("stall_start_cycle", md_stall, 1'b1);
            model(2'd0, 32'd5, 32'd7, ref_hi, ref_lo);
            e.hi = ref_hi;
            e.lo = ref_lo;
            e.cycles = MUL_N;
            sb.push_back(e);
            tick();
            start = 1'b0;
            allow_illegal = 1;
            for (int k = 1; k <= int'(MUL_N); k++) begin
                if (k == 2) begin
                    start = 1'b1;
                    op = 2'd1;
                    a = 32'hFFFF_FFFF;
                    b = 32'hFFFF_FFFF;
                end else begin
                    start = 1'b0;
                end
                #1;
                chk("busy_hold", busy, 1'b1);
                chk("stall_busy", md_stall, 1'b1);
                tick();
            end
            start = 1'b0;
            #1;
            chk("busy_drop", busy, 1'b0);
            chk("stall_drop", md_stall, 1'b0);
            chk("first_op_only_lo", lo, 32'd35);
            md_use_id = 1'b0;
            allow_illegal = 0;
        end

        // Reset in the third busy cycle of a DIV
        start = 1'b1;
        op = 2'd2;
        a = 32'd100;
        b = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_reset_busy", busy, 1'b1);
        abort = 1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        issue(2'd0, 32'd2, 32'd3, 1'b0);
        chk("post_rst_lo", lo, 32'd6);

        // Randomized traffic, back-to-back where the gap is zero
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 5) == 0)
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            issue(ro, ra, rb, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        tick();
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("illegal_issue_count", illegal_cnt, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
